// File: rtl/sr_cmd_gen_if.sv
// rtl/sr_cmd_gen_if.sv - button inputs and latch command outputs of sr_cmd_gen
interface sr_cmd_gen_if;
  logic btn_set;
  logic btn_reset;
  logic S;
  logic R;
  logic q_model;
  logic locked;

  // Front panel side: drives the raw buttons, watches the latch commands
  modport master (
    output btn_set,
    output btn_reset,
    input  S,
    input  R,
    input  q_model,
    input  locked
  );

  // Command generator side
  modport slave (
    input  btn_set,
    input  btn_reset,
    output S,
    output R,
    output q_model,
    output locked
  );
endinterface

// File: rtl/sr_cmd_gen.sv
// rtl/sr_cmd_gen.sv - debounced, mutually exclusive one-cycle S/R pulse generator for latch_sr
module sr_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input logic         clk,
  input logic         rst_n,
  sr_cmd_gen_if.slave sr_if
);

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, LOCK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             set_s1_q, set_s2_q, rst_s1_q, rst_s2_q;
  logic             set_db_q, set_db_d, rst_db_q, rst_db_d;
  logic             set_pv_q, rst_pv_q;
  logic [CNT_W-1:0] set_cnt_q, set_cnt_d, rst_cnt_q, rst_cnt_d;
  state_t           state_q, state_d;
  logic             q_model_q, q_model_d;
  logic             s_q, r_q, locked_q;
  logic             set_rise, rst_rise;

  // Rising edges of the debounced levels, one cycle after the level flips
  assign set_rise = set_db_q & ~set_pv_q;
  assign rst_rise = rst_db_q & ~rst_pv_q;

  // Debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    set_db_d  = set_db_q;
    set_cnt_d = '0;
    rst_db_d  = rst_db_q;
    rst_cnt_d = '0;
    if (set_s2_q != set_db_q) begin
      if (set_cnt_q == CNT_MAX) set_db_d = ~set_db_q;
      else                      set_cnt_d = set_cnt_q + 1'b1;
    end
    if (rst_s2_q != rst_db_q) begin
      if (rst_cnt_q == CNT_MAX) rst_db_d = ~rst_db_q;
      else                      rst_cnt_d = rst_cnt_q + 1'b1;
    end
  end

  // Command FSM: reset request has priority, redundant requests only lock
  always_comb begin
    state_d   = state_q;
    q_model_d = q_model_q;
    case (state_q)
      IDLE: begin
        if (rst_rise)      state_d = q_model_q ? PULSE_R : LOCK;
        else if (set_rise) state_d = q_model_q ? LOCK : PULSE_S;
      end
      PULSE_S: begin
        q_model_d = 1'b1;
        state_d   = LOCK;
      end
      PULSE_R: begin
        q_model_d = 1'b0;
        state_d   = LOCK;
      end
      LOCK: begin
        if (!set_db_q && !rst_db_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchronizers, debouncers and edge-detect history for both buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_s1_q  <= 1'b0;
      set_s2_q  <= 1'b0;
      rst_s1_q  <= 1'b0;
      rst_s2_q  <= 1'b0;
      set_db_q  <= 1'b0;
      rst_db_q  <= 1'b0;
      set_pv_q  <= 1'b0;
      rst_pv_q  <= 1'b0;
      set_cnt_q <= '0;
      rst_cnt_q <= '0;
    end else begin
      set_s1_q  <= sr_if.btn_set;
      set_s2_q  <= set_s1_q;
      rst_s1_q  <= sr_if.btn_reset;
      rst_s2_q  <= rst_s1_q;
      set_db_q  <= set_db_d;
      rst_db_q  <= rst_db_d;
      set_pv_q  <= set_db_q;
      rst_pv_q  <= rst_db_q;
      set_cnt_q <= set_cnt_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // State, latch model and registered outputs so S/R never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      q_model_q <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_model_q <= q_model_d;
      s_q       <= (state_d == PULSE_S);
      r_q       <= (state_d == PULSE_R);
      locked_q  <= (state_d == LOCK);
    end
  end

  assign sr_if.S       = s_q;
  assign sr_if.R       = r_q;
  assign sr_if.q_model = q_model_q;
  assign sr_if.locked  = locked_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb/tb_sr_cmd_gen.sv - randomized self-checking bench for sr_cmd_gen against a behavioural model
module tb_sr_cmd_gen;

  localparam int D = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_spulse;
  int   n_rpulse;
  int   first_s;

  sr_cmd_gen_if ifc ();

  sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sr_if (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: raw sample history per button, debounced levels and latch view
  logic [D:0] h_s, h_r;
  logic       m_db_s, m_db_r, m_pv_s, m_pv_r;
  logic       m_s, m_r, m_q, m_lock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    h_s = '0; h_r = '0;
    m_db_s = 0; m_db_r = 0; m_pv_s = 0; m_pv_r = 0;
    m_s = 0; m_r = 0; m_q = 0; m_lock = 0;
  endtask

  // A level flips once the last D synchronized samples all disagree with it
  function automatic logic flips(input logic [D:0] h, input logic lvl);
    logic all_diff;
    all_diff = 1'b1;
    for (int i = 1; i <= D; i++) if (h[i] == lvl) all_diff = 1'b0;
    return all_diff;
  endfunction

  task automatic model_step(input logic bs, input logic br);
    logic rise_s, rise_r, n_s, n_r, n_q, n_lock;
    rise_s = m_db_s & ~m_pv_s;
    rise_r = m_db_r & ~m_pv_r;
    n_q    = m_s ? 1'b1 : (m_r ? 1'b0 : m_q);
    n_s = 0; n_r = 0; n_lock = 0;
    if (m_s || m_r)  n_lock = 1;
    else if (m_lock) n_lock = m_db_s | m_db_r;
    else if (rise_r) begin if (m_q) n_r = 1; else n_lock = 1; end
    else if (rise_s) begin if (!m_q) n_s = 1; else n_lock = 1; end
    m_pv_s = m_db_s;
    m_pv_r = m_db_r;
    if (flips(h_s, m_db_s)) m_db_s = ~m_db_s;
    if (flips(h_r, m_db_r)) m_db_r = ~m_db_r;
    h_s = {h_s[D-1:0], bs};
    h_r = {h_r[D-1:0], br};
    m_s = n_s; m_r = n_r; m_q = n_q; m_lock = n_lock;
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge
  task automatic tick(input logic bs, input logic br);
    ifc.btn_set   = bs;
    ifc.btn_reset = br;
    @(posedge clk);
    if (rst_n) model_step(bs, br);
    @(negedge clk);
    check("S", 32'(ifc.S), 32'(m_s));
    check("R", 32'(ifc.R), 32'(m_r));
    check("q_model", 32'(ifc.q_model), 32'(m_q));
    check("locked", 32'(ifc.locked), 32'(m_lock));
    check("S_and_R", 32'(ifc.S & ifc.R), 32'd0);
    if (ifc.S) n_spulse++;
    if (ifc.R) n_rpulse++;
  endtask

  task automatic hold(input logic bs, input logic br, input int n);
    for (int i = 0; i < n; i++) tick(bs, br);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_S", 32'(ifc.S), 32'd0);
    check("rst_R", 32'(ifc.R), 32'd0);
    check("rst_q_model", 32'(ifc.q_model), 32'd0);
    check("rst_locked", 32'(ifc.locked), 32'd0);
    model_reset();
    for (int i = 0; i < 3; i++) tick(1'($urandom), 1'($urandom));
    rst_n = 1'b1;
  endtask

  task automatic clear_counts();
    n_spulse = 0;
    n_rpulse = 0;
  endtask

  initial begin
    logic bs, br;
    int   got;
    n_checks = 0; n_errors = 0;
    clear_counts();
    rst_n = 1'b0;
    ifc.btn_set = 1'b0;
    ifc.btn_reset = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset with toggling buttons, then quiet idle
    do_reset();
    hold(0, 0, 6);
    check("idle_locked", 32'(ifc.locked), 32'd0);

    // Clean press: one S pulse at the documented latency
    clear_counts();
    first_s = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1, 0);
      if (ifc.S && first_s < 0) first_s = i;
    end
    check("press_latency", 32'(first_s), 32'(D + 3));
    check("press_s_count", 32'(n_spulse), 32'd1);
    check("press_q", 32'(ifc.q_model), 32'd1);
    check("press_locked", 32'(ifc.locked), 32'd1);
    hold(0, 0, 12);
    check("release_locked", 32'(ifc.locked), 32'd0);

    // Clear the latch, then a bouncing set press and bouncing release
    hold(0, 1, 12);
    hold(0, 0, 12);
    check("clear_q", 32'(ifc.q_model), 32'd0);
    clear_counts();
    hold(1, 0, 2); hold(0, 0, 2); hold(1, 0, 2); hold(0, 0, 2);
    hold(1, 0, 15);
    hold(0, 0, 2); hold(1, 0, 2); hold(0, 0, 14);
    check("bounce_s_count", 32'(n_spulse), 32'd1);
    check("bounce_r_count", 32'(n_rpulse), 32'd0);

    // Simultaneous press with latch set: reset wins
    clear_counts();
    hold(1, 1, 12);
    check("both_r_count", 32'(n_rpulse), 32'd1);
    check("both_s_count", 32'(n_spulse), 32'd0);
    check("both_q", 32'(ifc.q_model), 32'd0);
    hold(0, 0, 12);
    check("both_release_locked", 32'(ifc.locked), 32'd0);

    // Redundant press, ignored second button, then a real reset
    hold(1, 0, 12);
    hold(0, 0, 12);
    clear_counts();
    hold(1, 0, 12);
    check("redundant_s_count", 32'(n_spulse), 32'd0);
    check("redundant_locked", 32'(ifc.locked), 32'd1);
    hold(1, 1, 12);
    check("ignored_r_count", 32'(n_rpulse), 32'd0);
    hold(0, 0, 12);
    hold(0, 1, 12);
    check("late_r_count", 32'(n_rpulse), 32'd1);
    hold(0, 0, 12);

    // Reset landing on the S pulse, then a full-latency re-press
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick(1, 0);
      if (ifc.S) got = 1;
    end
    check("pulse_seen", 32'(got), 32'd1);
    do_reset();
    clear_counts();
    first_s = -1;
    for (int i = 1; i <= 15; i++) begin
      tick(1, 0);
      if (ifc.S && first_s < 0) first_s = i;
    end
    check("repress_latency", 32'(first_s), 32'(D + 3));
    hold(0, 0, 12);

    // Random button activity with occasional resets
    bs = 0; br = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, ((i / 1000) % 2 == 0) ? 7 : 20) == 0) bs = ~bs;
      if ($urandom_range(0, ((i / 1000) % 2 == 0) ? 7 : 20) == 0) br = ~br;
      if ($urandom_range(0, 599) == 0) do_reset();
      tick(bs, br);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
